// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer controller: FSM state encoding.
package timer_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// CPU-side control/status and counter-chain pins of the interval timer controller.
interface interval_timer_ctrl_if #(
  parameter int unsigned WIDTH = 16
);

  logic [WIDTH-1:0] period;
  logic             period_we;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic             tick;
  logic             irq_ack;
  logic [WIDTH-1:0] ctr_q;
  logic             ctr_rco;
  logic             ctr_clr_n;
  logic             ctr_load_n;
  logic             ctr_enp;
  logic             ctr_ent;
  logic [WIDTH-1:0] ctr_p;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             irq;
  logic             overrun;

  // Driven by the CPU side and the counter chain.
  modport master (
    output period, period_we, start, stop, auto_reload, tick, irq_ack,
    output ctr_q, ctr_rco,
    input  ctr_clr_n, ctr_load_n, ctr_enp, ctr_ent, ctr_p,
    input  count, busy, irq, overrun
  );

  // The controller itself.
  modport slave (
    input  period, period_we, start, stop, auto_reload, tick, irq_ack,
    input  ctr_q, ctr_rco,
    output ctr_clr_n, ctr_load_n, ctr_enp, ctr_ent, ctr_p,
    output count, busy, irq, overrun
  );

endinterface

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer controller sequencing an external chain of
// cascaded 4-bit counter slices; terminal count is the top-slice rco.
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  interval_timer_ctrl_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] period_reg;
  logic             irq_r;
  logic             overrun_r;
  logic             busy_r;
  logic             clr_pend;
  logic             expire;
  logic             load_n;
  logic             enp;
  logic             ent;

  assign expire = (state == RUN) && bus.tick && bus.ctr_rco;

  // State, shadow period and sticky status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      period_reg <= '0;
      irq_r      <= 1'b0;
      overrun_r  <= 1'b0;
      busy_r     <= 1'b0;
      clr_pend   <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy_r   <= (state_nxt == ARM) || (state_nxt == RUN);
      clr_pend <= bus.stop;
      if (bus.period_we) begin
        period_reg <= bus.period;
      end
      if (expire) begin
        irq_r <= 1'b1;
      end else if (bus.irq_ack) begin
        irq_r <= 1'b0;
      end
      if (expire && irq_r) begin
        overrun_r <= 1'b1;
      end else if (bus.irq_ack) begin
        overrun_r <= 1'b0;
      end
    end
  end

  // Next state and chain control decode; on auto-reload the load overrides the increment.
  always_comb begin
    state_nxt = state;
    load_n    = 1'b1;
    enp       = 1'b0;
    ent       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = ARM;
        end
      end
      ARM: begin
        load_n    = 1'b0;
        state_nxt = RUN;
      end
      RUN: begin
        ent = 1'b1;
        enp = bus.tick;
        if (expire) begin
          if (bus.auto_reload) begin
            load_n = 1'b0;
          end else begin
            enp       = 1'b0;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (bus.start) begin
      state_nxt = ARM;
    end
    if (bus.stop) begin
      state_nxt = IDLE;
    end
  end

  assign bus.ctr_load_n = load_n;
  assign bus.ctr_enp    = enp;
  assign bus.ctr_ent    = ent;
  // Chain counts up from -N so that rco marks the N-th tick.
  assign bus.ctr_p      = WIDTH'(0) - period_reg;
  assign bus.count      = bus.ctr_q - bus.ctr_p;
  assign bus.ctr_clr_n  = ~(rst | clr_pend);
  assign bus.busy       = busy_r;
  assign bus.irq        = irq_r;
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl with a behavioural chain of
// 4-bit synchronous counter slices (async clear, sync load, enp/ent, rco).
module tb_interval_timer_ctrl;

  localparam int unsigned W  = 16;
  localparam int unsigned NS = W / 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  interval_timer_ctrl_if #(.WIDTH(W)) bus ();

  interval_timer_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Counter chain: each slice's ent is the rco of the slice below.
  logic [3:0]  slice_q [NS];
  logic [NS:0] ent_v;

  assign ent_v[0] = bus.ctr_ent;

  for (genvar i = 0; i < NS; i++) begin : g_slice
    always_ff @(posedge clk or negedge bus.ctr_clr_n) begin
      if (!bus.ctr_clr_n) begin
        slice_q[i] <= 4'h0;
      end else if (!bus.ctr_load_n) begin
        slice_q[i] <= bus.ctr_p[4*i +: 4];
      end else if (bus.ctr_enp && ent_v[i]) begin
        slice_q[i] <= slice_q[i] + 4'd1;
      end
    end
    assign ent_v[i+1] = ent_v[i] & (slice_q[i] == 4'hF);
  end

  always_comb begin
    bus.ctr_q = '0;
    for (int i = 0; i < NS; i++) begin
      bus.ctr_q[4*i +: 4] = slice_q[i];
    end
  end
  assign bus.ctr_rco = ent_v[NS];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_period(input logic [W-1:0] p);
    bus.period    = p;
    bus.period_we = 1'b1;
    cyc(1);
    bus.period_we = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  logic [W-1:0] seq2 [3];

  initial begin
    n_cmp = 0;
    n_err = 0;
    seq2[0] = 16'hFFFE;
    seq2[1] = 16'hFFFF;
    seq2[2] = 16'hFFFD;
    bus.period      = '0;
    bus.period_we   = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.auto_reload = 1'b0;
    bus.tick        = 1'b0;
    bus.irq_ack     = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_irq",    32'(bus.irq),        32'h0);
    check("rst_busy",   32'(bus.busy),       32'h0);
    check("rst_clr_n",  32'(bus.ctr_clr_n),  32'h0);
    check("rst_load_n", 32'(bus.ctr_load_n), 32'h1);
    check("rst_enp",    32'(bus.ctr_enp),    32'h0);
    check("rst_ent",    32'(bus.ctr_ent),    32'h0);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("idle_clr_n", 32'(bus.ctr_clr_n), 32'h1);

    // One-shot, N=5, tick every cycle; tick during ARM is lost.
    write_period(16'd5);
    check("p5_ctr_p", 32'(bus.ctr_p), 32'hFFFB);
    pulse_start();
    check("p5_arm_busy",   32'(bus.busy),       32'h1);
    check("p5_arm_load_n", 32'(bus.ctr_load_n), 32'h0);
    bus.tick = 1'b1;
    cyc(1);
    check("p5_loaded", 32'(bus.ctr_q), 32'hFFFB);
    check("p5_count0", 32'(bus.count), 32'h0);
    cyc(4);
    check("p5_q_pre",   32'(bus.ctr_q), 32'hFFFF);
    check("p5_irq_pre", 32'(bus.irq),   32'h0);
    cyc(1);
    check("p5_irq",  32'(bus.irq),   32'h1);
    check("p5_busy", 32'(bus.busy),  32'h0);
    check("p5_q",    32'(bus.ctr_q), 32'hFFFF);
    bus.tick = 1'b0;
    cyc(3);
    check("p5_count_hold", 32'(bus.count),   32'h4);
    check("p5_done_ent",   32'(bus.ctr_ent), 32'h0);
    bus.irq_ack = 1'b1;
    cyc(1);
    bus.irq_ack = 1'b0;
    check("p5_ack", 32'(bus.irq), 32'h0);

    // Auto-reload N=3, tick every other cycle, ack each irq.
    bus.auto_reload = 1'b1;
    write_period(16'd3);
    pulse_start();
    cyc(1);
    check("p3_loaded", 32'(bus.ctr_q), 32'hFFFD);
    for (int j = 0; j < 9; j++) begin
      bus.tick = 1'b1;
      cyc(1);
      bus.tick = 1'b0;
      check($sformatf("p3_q%0d", j), 32'(bus.ctr_q), 32'(seq2[j % 3]));
      if (j % 3 == 2) begin
        check($sformatf("p3_irq%0d", j), 32'(bus.irq), 32'h1);
        bus.irq_ack = 1'b1;
        cyc(1);
        bus.irq_ack = 1'b0;
        check($sformatf("p3_ack%0d", j), 32'(bus.irq), 32'h0);
      end else begin
        check($sformatf("p3_noirq%0d", j), 32'(bus.irq), 32'h0);
        cyc(1);
      end
    end
    check("p3_overrun", 32'(bus.overrun), 32'h0);

    // N=1 auto-reload, never acked: overrun on second expiry, set beats ack.
    write_period(16'd1);
    pulse_start();
    cyc(1);
    check("p1_q",   32'(bus.ctr_q),   32'hFFFF);
    check("p1_rco", 32'(bus.ctr_rco), 32'h1);
    bus.tick = 1'b1;
    cyc(1);
    check("p1_irq1", 32'(bus.irq),     32'h1);
    check("p1_ovr1", 32'(bus.overrun), 32'h0);
    cyc(1);
    check("p1_ovr2", 32'(bus.overrun), 32'h1);
    bus.irq_ack = 1'b1;
    cyc(1);
    check("p1_ack_irq", 32'(bus.irq),     32'h1);
    check("p1_ack_ovr", 32'(bus.overrun), 32'h1);
    check("p1_busy",    32'(bus.busy),    32'h1);
    bus.tick = 1'b0;
    cyc(1);
    bus.irq_ack = 1'b0;
    check("p1_clr_irq", 32'(bus.irq),     32'h0);
    check("p1_clr_ovr", 32'(bus.overrun), 32'h0);

    // N=0 means 2^16 ticks.
    bus.auto_reload = 1'b0;
    write_period(16'd0);
    pulse_start();
    cyc(1);
    check("p0_loaded", 32'(bus.ctr_q), 32'h0);
    bus.tick = 1'b1;
    cyc(65535);
    check("p0_q_pre",   32'(bus.ctr_q), 32'hFFFF);
    check("p0_irq_pre", 32'(bus.irq),   32'h0);
    cyc(1);
    check("p0_irq",   32'(bus.irq),   32'h1);
    check("p0_busy",  32'(bus.busy),  32'h0);
    check("p0_count", 32'(bus.count), 32'hFFFF);
    bus.tick    = 1'b0;
    bus.irq_ack = 1'b1;
    cyc(1);
    bus.irq_ack = 1'b0;

    // Period rewrite mid-interval only takes effect at the next reload.
    bus.auto_reload = 1'b1;
    write_period(16'd2);
    pulse_start();
    cyc(1);
    check("pw_loaded", 32'(bus.ctr_q), 32'hFFFE);
    bus.tick      = 1'b1;
    bus.period    = 16'd8;
    bus.period_we = 1'b1;
    cyc(1);
    bus.period_we = 1'b0;
    check("pw_q_mid", 32'(bus.ctr_q), 32'hFFFF);
    cyc(1);
    check("pw_reload", 32'(bus.ctr_q), 32'hFFF8);
    check("pw_irq",    32'(bus.irq),   32'h1);
    bus.irq_ack = 1'b1;
    cyc(1);
    bus.irq_ack = 1'b0;
    cyc(6);
    check("pw_q8_pre",   32'(bus.ctr_q), 32'hFFFF);
    check("pw_irq8_pre", 32'(bus.irq),   32'h0);
    cyc(1);
    check("pw_irq8", 32'(bus.irq),   32'h1);
    check("pw_q8",   32'(bus.ctr_q), 32'hFFF8);

    // Stop beats start; chain clear lasts one cycle.
    bus.tick  = 1'b0;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("ss_busy",  32'(bus.busy),      32'h0);
    check("ss_clr_n", 32'(bus.ctr_clr_n), 32'h0);
    check("ss_q",     32'(bus.ctr_q),     32'h0);
    cyc(1);
    check("ss_clr_n_end", 32'(bus.ctr_clr_n), 32'h1);
    check("ss_idle_busy", 32'(bus.busy),      32'h0);

    // Asynchronous reset mid-RUN.
    bus.irq_ack = 1'b1;
    cyc(1);
    bus.irq_ack = 1'b0;
    pulse_start();
    cyc(1);
    check("ar_loaded", 32'(bus.ctr_q), 32'hFFF8);
    bus.tick = 1'b1;
    cyc(2);
    check("ar_count2", 32'(bus.count), 32'h2);
    #2 rst = 1'b1;
    #1;
    check("ar_busy",  32'(bus.busy),      32'h0);
    check("ar_clr_n", 32'(bus.ctr_clr_n), 32'h0);
    check("ar_enp",   32'(bus.ctr_enp),   32'h0);
    check("ar_irq",   32'(bus.irq),       32'h0);
    check("ar_q",     32'(bus.ctr_q),     32'h0);
    bus.tick = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("ar_idle_ent", 32'(bus.ctr_ent), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
